alu8_driver: RTL

ALU8_DRIVER -- requirements
Module: alu8_driver

---
 rtl/alu8_pkg.sv | 44 ++++
 rtl/alu8_driver_if.sv | 46 ++++
 rtl/alu8_cmd_fifo.sv | 67 ++++++
 rtl/alu8_driver.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu8_pkg.sv
// Purpose: shared types and constants for the alu8 command driver slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu8_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 2;
    localparam int FLAG_W = 3;

    // ALU opcodes, passed to the ALU unmodified
    localparam logic [OP_W-1:0] OP_ILL0 = 3'd0;
    localparam logic [OP_W-1:0] OP_AND  = 3'd1;
    localparam logic [OP_W-1:0] OP_OR   = 3'd2;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND = 3'd4;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_ILL6 = 3'd6;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd7;

    // Bit positions inside rsp_flags = {overf, carry, zero}
    localparam logic [1:0] FLAG_ZERO  = 2'd0;
    localparam logic [1:0] FLAG_CARRY = 2'd1;
    localparam logic [1:0] FLAG_OVERF = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } fifo_entry_t;

    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op == OP_ILL0) || (op == OP_ILL6);
    endfunction

endpackage

// File: rtl/alu8_driver_if.sv
// Purpose: bundles the command, ALU and response signals of the alu8 driver.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready on intake, rsp_valid/rsp_ready on response.
interface alu8_driver_if;
    import alu8_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [OP_W-1:0]      cmd_op;
    logic [DATA_W-1:0]    cmd_a;
    logic [DATA_W-1:0]    cmd_b;

    logic [DATA_W-1:0]    alu_inA;
    logic [DATA_W-1:0]    alu_inB;
    logic [OP_W-1:0]      alu_sel;
    logic [DATA_W-1:0]    alu_result;
    logic                 alu_zero;
    logic                 alu_carry;
    logic                 alu_overf;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_W-1:0]    rsp_result;
    logic [FLAG_W-1:0]    rsp_flags;
    logic [TAG_W-1:0]     rsp_tag;
    logic                 rsp_err;

    logic                 busy;

    // Environment side: command source, response sink and the ALU itself
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output alu_result, alu_zero, alu_carry, alu_overf,
        input  cmd_ready, alu_inA, alu_inB, alu_sel,
        input  rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err, busy
    );

    // Driver side
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  alu_result, alu_zero, alu_carry, alu_overf,
        output cmd_ready, alu_inA, alu_inB, alu_sel,
        output rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err, busy
    );

endinterface

// File: rtl/alu8_cmd_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO of queued ALU commands with full/empty flags.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are dropped; flags come from registered count.
module alu8_cmd_fifo
    import alu8_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  fifo_entry_t push_dat_i,
    input  logic        pop_i,
    output fifo_entry_t pop_dat_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Next pointers/occupancy; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state, cleared asynchronously to drop all queued commands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/alu8_driver.sv
// Purpose: queues tagged commands and sequences them through a registered 8-bit ALU; ALU8_DRV_ILLEGAL_OP_EN short-circuits ops 0/6 with rsp_err.
// Latency: accept at edge N into an idle, empty block -> rsp_valid after edge N+3 (N+2 for short-circuited ops).
// Backpressure: cmd_ready = !fifo_full from registered state; response held stable until rsp_ready.
module alu8_driver
    import alu8_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    alu8_driver_if.slave bus
);

    state_t              state_q;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [DATA_W-1:0]   alu_inA_q;
    logic [DATA_W-1:0]   alu_inB_q;
    logic [OP_W-1:0]     alu_sel_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic [FLAG_W-1:0]   rsp_flags_q;
    logic [TAG_W-1:0]    rsp_tag_q;

    logic                cmd_acc;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    fifo_entry_t         push_dat;
    fifo_entry_t         head;

    assign cmd_acc  = bus.cmd_valid && !fifo_full;
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
    assign push_dat = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, tag: tag_q};

    alu8_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (cmd_acc),
        .push_dat_i (push_dat),
        .pop_i      (fifo_pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Tag advances once per accepted command and wraps naturally
    assign tag_d = cmd_acc ? tag_q + TAG_W'(1) : tag_q;

    // Tag counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tag_q <= '0;
        else       tag_q <= tag_d;
    end

`ifdef ALU8_DRV_ILLEGAL_OP_EN
    logic rsp_err_q;
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Sequencer: pop -> drive ALU -> capture its registered result -> hold response until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            alu_inA_q    <= '0;
            alu_inB_q    <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_tag_q    <= '0;
`ifdef ALU8_DRV_ILLEGAL_OP_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        // rsp_valid is low here, so the tag can be staged early
                        rsp_tag_q <= head.tag;
`ifdef ALU8_DRV_ILLEGAL_OP_EN
                        if (is_illegal_op(head.op)) begin
                            // ALU operands keep their last issued values
                            state_q <= ST_RESPOND;
                        end else begin
                            alu_inA_q <= head.a;
                            alu_inB_q <= head.b;
                            alu_sel_q <= head.op;
                            state_q   <= ST_ISSUE;
                        end
`else
                        alu_inA_q <= head.a;
                        alu_inB_q <= head.b;
                        alu_sel_q <= head.op;
                        state_q   <= ST_ISSUE;
`endif
                    end
                end
                ST_ISSUE: begin
                    // ALU registers its result on this edge
                    state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_result_q             <= bus.alu_result;
                    rsp_flags_q[FLAG_ZERO]   <= bus.alu_zero;
                    rsp_flags_q[FLAG_CARRY]  <= bus.alu_carry;
                    rsp_flags_q[FLAG_OVERF]  <= bus.alu_overf;
                    rsp_valid_q              <= 1'b1;
`ifdef ALU8_DRV_ILLEGAL_OP_EN
                    rsp_err_q                <= 1'b0;
`endif
                    state_q                  <= ST_RESPOND;
                end
                ST_RESPOND: begin
`ifdef ALU8_DRV_ILLEGAL_OP_EN
                    if (!rsp_valid_q) begin
                        // Arrived straight from IDLE with an illegal op: post the error response
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= '0;
                        rsp_flags_q  <= '0;
                        rsp_err_q    <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
`else
                    if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = !fifo_full;
    assign bus.alu_inA    = alu_inA_q;
    assign bus.alu_inB    = alu_inB_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule
